cv32e40p_hwloop_shuffle_ctrl: RTL



---
 rtl/cv32e40p_hwloop_pkg.sv | 17 +
 rtl/cv32e40p_hwloop_rr_arbiter.sv | 32 +++
 rtl/cv32e40p_hwloop_shuffle_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_hwloop_pkg.sv
// Shared types and constants for the hwloop shuffled-index controller.
// CV32E40P_HWLOOP_PREFETCH_EN selects the 2-entry prefetch FIFO variant.
package cv32e40p_hwloop_pkg;

  localparam int unsigned NUM_LOOPS_DEF  = 2;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned PREFETCH_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W     = $clog2(PREFETCH_DEPTH);
  localparam int unsigned FIFO_CNT_W     = FIFO_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/cv32e40p_hwloop_rr_arbiter.sv
// Round-robin arbiter: prio is the first loop checked; returns one-hot grant and its id.
module cv32e40p_hwloop_rr_arbiter
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned NUM_LOOPS = NUM_LOOPS_DEF,
  parameter int unsigned LOOP_BITS = $clog2(NUM_LOOPS)
) (
  input  logic [NUM_LOOPS-1:0] req,
  input  logic [LOOP_BITS-1:0] prio,
  output logic [NUM_LOOPS-1:0] grant,
  output logic [LOOP_BITS-1:0] grant_id
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
      idx = 32'(prio) + k;
      if (idx >= NUM_LOOPS) idx = idx - NUM_LOOPS;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        grant_id  = LOOP_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/cv32e40p_hwloop_shuffle_ctrl.sv
// Shares one shuffled-index generator between hwloop contexts and feeds indices to the owner.
// CV32E40P_HWLOOP_PREFETCH_EN swaps the single index register for a 2-entry prefetch FIFO.
module cv32e40p_hwloop_shuffle_ctrl
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned NUM_LOOPS = NUM_LOOPS_DEF,
  parameter int unsigned LOOP_BITS = $clog2(NUM_LOOPS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LOOPS-1:0]            start_i,
  input  logic [NUM_LOOPS-1:0][CNT_W-1:0] count_i,
  output logic [NUM_LOOPS-1:0]            start_ready_o,
  input  logic [NUM_LOOPS-1:0]            abort_i,
  output logic [CNT_W-1:0]                index_o,
  output logic [NUM_LOOPS-1:0]            index_valid_o,
  input  logic [NUM_LOOPS-1:0]            index_ack_i,
  output logic [NUM_LOOPS-1:0]            done_o,
  output logic                            busy_o,
  output logic                            gen_valid_o,
  output logic [CNT_W-1:0]                gen_num_iter_o,
  output logic                            gen_next_o,
  input  logic [CNT_W-1:0]                gen_index_i
);

  state_e               state_q;
  logic [LOOP_BITS-1:0] owner_q, prio_q, prio_nxt;
  logic [CNT_W-1:0]     remaining_q;
  logic [NUM_LOOPS-1:0] done_q;
  logic [NUM_LOOPS-1:0] grant;
  logic [LOOP_BITS-1:0] grant_id;
  logic [CNT_W-1:0]     sel_count, head;
  logic                 idle, accept, own_abort, own_ack;
  logic                 out_valid, pop, last_pop;

`ifdef CV32E40P_HWLOOP_PREFETCH_EN
  logic [PREFETCH_DEPTH-1:0][CNT_W-1:0] fifo_q;
  logic [FIFO_PTR_W-1:0]                rd_ptr_q, wr_ptr_q;
  logic [FIFO_CNT_W-1:0]                fifo_cnt_q, occ_next;
  logic                                 pend_q, push;
  logic [CNT_W-1:0]                     issued_q, total_q;
`else
  logic [CNT_W-1:0]                     idx_q;
`endif

  cv32e40p_hwloop_rr_arbiter #(
    .NUM_LOOPS (NUM_LOOPS),
    .LOOP_BITS (LOOP_BITS)
  ) u_arb (
    .req      (start_i),
    .prio     (prio_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant, generator strobes and index handshake, all decided from registered state.
  always_comb begin
    idle           = (state_q == IDLE);
    busy_o         = !idle;
    start_ready_o  = idle ? grant : '0;
    accept         = |(start_i & start_ready_o);
    sel_count      = count_i[grant_id];
    gen_valid_o    = accept && (sel_count != '0);
    gen_num_iter_o = gen_valid_o ? sel_count : '0;
    prio_nxt       = (32'(grant_id) == NUM_LOOPS - 1) ? '0 : grant_id + LOOP_BITS'(1);
    own_abort      = !idle && abort_i[owner_q];
    own_ack        = index_ack_i[owner_q];
`ifdef CV32E40P_HWLOOP_PREFETCH_EN
    out_valid      = !idle && (fifo_cnt_q != '0);
    head           = fifo_q[rd_ptr_q];
    push           = !idle && pend_q;
`else
    out_valid      = (state_q == READY);
    head           = idx_q;
`endif
    index_valid_o  = out_valid ? (NUM_LOOPS'(1) << owner_q) : '0;
    index_o        = out_valid ? head : '0;
    pop            = out_valid && own_ack && !own_abort;
    last_pop       = pop && (remaining_q == CNT_W'(1));
`ifdef CV32E40P_HWLOOP_PREFETCH_EN
    occ_next       = fifo_cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    // Request ahead while there is room and indices left to generate.
    gen_next_o     = !idle && !own_abort && (occ_next < FIFO_CNT_W'(PREFETCH_DEPTH)) &&
                     (issued_q < total_q - CNT_W'(1));
`else
    gen_next_o     = pop && !last_pop;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      prio_q      <= '0;
      remaining_q <= '0;
      done_q      <= '0;
`ifdef CV32E40P_HWLOOP_PREFETCH_EN
      fifo_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      pend_q      <= 1'b0;
      issued_q    <= '0;
      total_q     <= '0;
`else
      idx_q       <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            prio_q <= prio_nxt;
            if (sel_count == '0) begin
              done_q <= grant;
            end else begin
              owner_q     <= grant_id;
              remaining_q <= sel_count;
              state_q     <= FILL;
`ifdef CV32E40P_HWLOOP_PREFETCH_EN
              total_q     <= sel_count;
              issued_q    <= '0;
              pend_q      <= 1'b1;
              fifo_cnt_q  <= '0;
              rd_ptr_q    <= '0;
              wr_ptr_q    <= '0;
`endif
            end
          end
        end
        default: begin
`ifdef CV32E40P_HWLOOP_PREFETCH_EN
          if (own_abort) begin
            state_q    <= IDLE;
            fifo_cnt_q <= '0;
            pend_q     <= 1'b0;
          end else begin
            if (push) begin
              fifo_q[wr_ptr_q] <= gen_index_i;
              wr_ptr_q         <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            if (pop && (remaining_q != '0)) remaining_q <= remaining_q - CNT_W'(1);
            if (gen_next_o) issued_q <= issued_q + CNT_W'(1);
            fifo_cnt_q <= occ_next;
            pend_q     <= gen_next_o;
            if (last_pop) begin
              done_q[owner_q] <= 1'b1;
              state_q         <= IDLE;
              fifo_cnt_q      <= '0;
              pend_q          <= 1'b0;
            end else begin
              state_q <= READY;
            end
          end
`else
          if (own_abort) begin
            state_q <= IDLE;
          end else if (state_q == FILL) begin
            idx_q   <= gen_index_i;
            state_q <= READY;
          end else if (pop) begin
            if (remaining_q != '0) remaining_q <= remaining_q - CNT_W'(1);
            if (last_pop) begin
              done_q[owner_q] <= 1'b1;
              state_q         <= IDLE;
            end else begin
              state_q <= FILL;
            end
          end
`endif
        end
      endcase
    end
  end

  assign done_o = done_q;

endmodule
